fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0000, is the instruction word driven when no valid instruction is presented.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 stall_id  input  1  decode stage cannot accept an instruction this cycle.
REQ-006 redirect  input  1  branch/jump taken; fetch resumes at redirect_pc.
REQ-007 redirect_pc  input  32  redirect target; bits [1:0] ignored and forced to 0.
REQ-008 imem_req  output  1  instruction memory request valid.
REQ-009 imem_addr  output  32  request address, word aligned.
REQ-010 imem_gnt  input  1  memory accepts the request in this cycle.
REQ-011 imem_rvalid  input  1  read data valid, one per granted request, at least 1 cycle after grant.
REQ-012 imem_rdata  input  32  instruction word, qualified by imem_rvalid.
REQ-013 PC_if  output  32  PC of the instruction presented to the decode pipeline register.
REQ-014 Inst_if  output  32  instruction presented to the decode pipeline register.
REQ-015 ifid_write  output  1  decode pipeline register loads PC_if/Inst_if at the next edge.
REQ-016 flush  output  1  decode pipeline register clears at the next edge.

Function
REQ-017 States: FETCH (request outstanding toward memory), WAIT (granted, awaiting data), HOLD (instruction buffered, decode stalled), DROP (stale response pending, discard it).
REQ-018 At most one request is in flight; imem_req = 1 only in FETCH and only while rst = 0, with imem_addr = pc.
REQ-019 FETCH: imem_gnt -> WAIT; otherwise stay, holding imem_req and imem_addr stable; imem_rvalid in FETCH is ignored.
REQ-020 WAIT, imem_rvalid and !stall_id: ifid_write = 1, PC_if = pc, Inst_if = imem_rdata in the same cycle (zero-cycle pass-through); pc <= pc + 4; -> FETCH.
REQ-021 WAIT, imem_rvalid and stall_id: buffer imem_rdata; ifid_write = 0; -> HOLD.
REQ-022 HOLD: Inst_if = buffer, PC_if = pc; ifid_write = !stall_id; when !stall_id, pc <= pc + 4 and -> FETCH.
REQ-023 Outside REQ-020/REQ-022 write cycles: ifid_write = 0, PC_if = pc, Inst_if = NOP_INST.
REQ-024 pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 redirect has priority over every other event: flush = redirect (combinational), ifid_write = 0, pc <= {redirect_pc[31:2], 2'b00}.
REQ-026 Redirect next-state: FETCH without gnt -> FETCH; FETCH with gnt -> DROP; WAIT without rvalid -> DROP; WAIT with rvalid -> FETCH, data discarded; HOLD -> FETCH, buffer discarded; DROP -> DROP.
REQ-027 DROP: imem_req = 0; imem_rvalid -> FETCH, data discarded; ifid_write = 0.
REQ-028 stall_id has no effect on FETCH, WAIT-without-rvalid or DROP progress.

Reset
REQ-029 rst asserted: state = FETCH, pc = RESET_PC, buffer = NOP_INST, imem_req = 0, ifid_write = 0, flush = 0.
REQ-030 First request, with imem_addr = RESET_PC, appears in the first cycle after rst deasserts.
REQ-031 Reset mid-transaction abandons the in-flight request; a late imem_rvalid arrives in FETCH and is ignored per REQ-019.

Structure
REQ-032 Package fetch_pkg holds the state enumeration, the default RESET_PC and NOP_INST constants, and the PC increment constant 4.
REQ-033 One sub-module, pc_reg: asynchronous-reset 32-bit PC register with load-target, increment and hold controls; remaining FSM, buffer and output muxing stay in fetch_unit.

Verification
REQ-034 rst 1->0, gnt tied 1, rvalid 1 cycle after grant, stall_id = 0 -> imem_addr sequence 0x0, 0x4, 0x8; ifid_write pulses with PC_if = 0x0, 0x4, 0x8 and matching Inst_if.
REQ-035 rdata 0x1234_5678 at PC 0x8 arrives with stall_id = 1 for 3 cycles -> HOLD, ifid_write = 0 for 3 cycles, then 1 cycle with Inst_if = 0x1234_5678, PC_if = 0x8, next imem_addr = 0xC.
REQ-036 redirect to 0x0000_0103 while in WAIT at PC 0x10 -> flush = 1 that cycle, DROP; stale rvalid discarded (no ifid_write); next imem_addr = 0x0000_0100.
REQ-037 redirect to 0x40 in the same cycle as imem_gnt in FETCH -> DROP, one rvalid discarded, then request at 0x40.
REQ-038 PC forced to 0xFFFF_FFFC via redirect, one fetch completes -> next imem_addr = 0x0000_0000.
REQ-039 rst pulsed while in WAIT, rvalid arrives 2 cycles after release -> no ifid_write from it; request at RESET_PC stays asserted until granted.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

  // Clears the byte-offset bits of an address.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: asynchronous reset, aligned load, +4 increment, hold.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic        inc,
  output logic [31:0] pc
);

  logic [31:0] pc_r;

  // Load wins over increment; the 32-bit add wraps naturally at the top of memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (load) begin
      pc_r <= align_word(load_pc);
    end else if (inc) begin
      pc_r <= pc_r + PC_INCR;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single outstanding memory request, decode-stall
// buffering and redirect handling with discard of stale responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_if,
  output logic [31:0] Inst_if,
  output logic        ifid_write,
  output logic        flush
);

  fetch_state_e state_r;
  fetch_state_e state_nxt_s;
  logic [31:0]  buf_r;
  logic [31:0]  pc_s;
  logic         pc_load_s;
  logic         pc_inc_s;
  logic         buf_load_s;
  logic         req_s;
  logic         write_s;
  logic [31:0]  inst_s;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load_s),
    .load_pc (redirect_pc),
    .inc     (pc_inc_s),
    .pc      (pc_s)
  );

  // Next-state and datapath control; redirect overrides every other event.
  always_comb begin
    state_nxt_s = state_r;
    pc_load_s   = 1'b0;
    pc_inc_s    = 1'b0;
    buf_load_s  = 1'b0;
    req_s       = 1'b0;
    write_s     = 1'b0;
    inst_s      = NOP_INST;
    case (state_r)
      ST_FETCH: begin
        req_s = 1'b1;
        if (redirect) begin
          pc_load_s   = 1'b1;
          state_nxt_s = imem_gnt ? ST_DROP : ST_FETCH;
        end else begin
          state_nxt_s = imem_gnt ? ST_WAIT : ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          pc_load_s   = 1'b1;
          state_nxt_s = imem_rvalid ? ST_FETCH : ST_DROP;
        end else if (imem_rvalid && !stall_id) begin
          write_s     = 1'b1;
          inst_s      = imem_rdata;
          pc_inc_s    = 1'b1;
          state_nxt_s = ST_FETCH;
        end else if (imem_rvalid) begin
          buf_load_s  = 1'b1;
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_load_s   = 1'b1;
          state_nxt_s = ST_FETCH;
        end else if (!stall_id) begin
          write_s     = 1'b1;
          inst_s      = buf_r;
          pc_inc_s    = 1'b1;
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_DROP: begin
        // A redirect here only retargets the PC; the one stale response
        // still pending is what releases this state.
        pc_load_s   = redirect;
        state_nxt_s = imem_rvalid ? ST_FETCH : ST_DROP;
      end
      default: begin
        state_nxt_s = ST_FETCH;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Holds a returned instruction while decode is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r <= NOP_INST;
    end else if (buf_load_s) begin
      buf_r <= imem_rdata;
    end else begin
      buf_r <= buf_r;
    end
  end

  assign imem_req   = req_s & ~rst;
  assign imem_addr  = pc_s;
  assign PC_if      = pc_s;
  assign Inst_if    = inst_s;
  assign ifid_write = write_s;
  assign flush      = redirect & ~rst;

endmodule
